// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter
// Weighted round-robin owner of a single 8x8 DCT engine shared by NREQ block
// producers. One 64-point block is in flight at a time: the arbiter grants a
// producer, passes its block to the engine, waits for the engine result,
// hands the result downstream tagged with the producer index, and only then
// arbitrates again. Payloads are muxed combinationally; no block is stored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-producer block handshake (NREQ bits)
//   req_data          producer r block at [r*64*IN_W +: 64*IN_W]
//   weight            per-producer 4-bit consecutive-grant budget (0 acts as 1)
//   eng_in_*          block handshake towards the engine
//   eng_out_*         result handshake from the engine
//   out_valid/ready   tagged result handshake downstream
//   out_data, out_id  result payload (equals eng_out_data) and owner index
//   blk_cnt           completed blocks per producer, CNT_W bits each, wrapping
//   busy              high whenever not arbitrating
//   dbg_state         current FSM state (S_ARB=0, S_ISSUE=1, S_WAIT=2)
//   dbg_credit        remaining consecutive-grant credit of the owner
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid never depends on ready; once raised, valid should be
// held with stable data until the transfer. ready may depend on valid.

module dct_block_arbiter #(
  parameter int IN_W  = 32,
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*64*IN_W-1:0]  req_data,
  input  logic [NREQ*4-1:0]        weight,
  output logic                     eng_in_valid,
  input  logic                     eng_in_ready,
  output logic [64*IN_W-1:0]       eng_in_data,
  input  logic                     eng_out_valid,
  output logic                     eng_out_ready,
  input  logic [64*IN_W-1:0]       eng_out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [64*IN_W-1:0]       out_data,
  output logic [2:0]               out_id,
  output logic [NREQ*CNT_W-1:0]    blk_cnt,
  output logic                     busy,
  output logic [1:0]               dbg_state,
  output logic [3:0]               dbg_credit
);

  localparam int BLK_W = 64 * IN_W;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  grant, grant_n;
  logic [2:0]  last, last_n;
  logic [3:0]  credit, credit_n;
  logic        cnt_inc;

  logic [NREQ-1:0] grant_oh;
  logic            valid_g;
  logic            rr_hit;
  logic [2:0]      rr_idx;
  logic [3:0]      w_new;

  // One-hot view of the owner avoids indexing NREQ-wide vectors with a
  // 3-bit pointer when NREQ is not a power of two.
  always_comb begin
    grant_oh = '0;
    for (int r = 0; r < NREQ; r++) begin
      grant_oh[r] = (grant == 3'(r));
    end
  end

  assign valid_g = |(req_valid & grant_oh);

  // Round-robin search: first valid requester at last+1, last+2, ... mod NREQ.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = grant;
    for (int i = 1; i <= NREQ; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!rr_hit && req_valid[r] && (((int'(last) + i) % NREQ) == r)) begin
          rr_hit = 1'b1;
          rr_idx = 3'(r);
        end
      end
    end
  end

  // Weight of the newly chosen requester, with 0 promoted to 1.
  always_comb begin
    w_new = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (rr_idx == 3'(r)) begin
        w_new = weight[r*4 +: 4];
      end
    end
    if (w_new == 4'd0) begin
      w_new = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ARB;
      grant   <= 3'd0;
      last    <= 3'(NREQ - 1);
      credit  <= 4'd0;
      blk_cnt <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      last   <= last_n;
      credit <= credit_n;
      for (int r = 0; r < NREQ; r++) begin
        if (cnt_inc && grant_oh[r]) begin
          blk_cnt[r*CNT_W +: CNT_W] <= blk_cnt[r*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    last_n   = last;
    credit_n = credit;
    cnt_inc  = 1'b0;
    case (state)
      S_ARB: begin
        if ((credit != 4'd0) && valid_g) begin
          // Owner still has credit and another block ready: keep it.
          state_n = S_ISSUE;
        end else if (rr_hit) begin
          // Credit exhausted or owner idle (forfeits what remains).
          grant_n  = rr_idx;
          last_n   = rr_idx;
          credit_n = w_new;
          state_n  = S_ISSUE;
        end else begin
          credit_n = 4'd0;
        end
      end
      S_ISSUE: begin
        if (valid_g && eng_in_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_out_valid && out_ready) begin
          cnt_inc  = 1'b1;
          credit_n = credit - 4'd1;
          state_n  = S_ARB;
        end
      end
      default: begin
        state_n = S_ARB;
      end
    endcase
  end

  // Pass-through handshakes, gated by state.
  always_comb begin
    eng_in_data = '0;
    if (state == S_ISSUE) begin
      for (int r = 0; r < NREQ; r++) begin
        if (grant_oh[r]) begin
          eng_in_data = req_data[r*BLK_W +: BLK_W];
        end
      end
    end
  end

  assign eng_in_valid  = (state == S_ISSUE) && valid_g;
  assign req_ready     = (state == S_ISSUE) ? (grant_oh & {NREQ{eng_in_ready}}) : '0;
  assign out_valid     = (state == S_WAIT) && eng_out_valid;
  assign eng_out_ready = (state == S_WAIT) && out_ready;
  assign out_data      = eng_out_data;
  assign out_id        = grant;
  assign busy          = (state != S_ARB);
  assign dbg_state     = state;
  assign dbg_credit    = credit;

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter
// Directed bench for dct_block_arbiter with a behavioural engine model
// (fixed 20-cycle latency, result equals the accepted block).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_dct_block_arbiter;

  localparam int IN_W  = 32;
  localparam int NREQ  = 3;
  localparam int CNT_W = 16;
  localparam int BLK_W = 64 * IN_W;
  localparam int LAT   = 20;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*BLK_W-1:0]   req_data;
  logic [NREQ*4-1:0]       weight;
  logic                    eng_in_valid;
  logic                    eng_in_ready;
  logic [BLK_W-1:0]        eng_in_data;
  logic                    eng_out_valid;
  logic                    eng_out_ready;
  logic [BLK_W-1:0]        eng_out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [BLK_W-1:0]        out_data;
  logic [2:0]              out_id;
  logic [NREQ*CNT_W-1:0]   blk_cnt;
  logic                    busy;
  logic [1:0]              dbg_state;
  logic [3:0]              dbg_credit;

  int n_cmp = 0;
  int n_err = 0;

  dct_block_arbiter #(
    .IN_W  (IN_W),
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .weight        (weight),
    .eng_in_valid  (eng_in_valid),
    .eng_in_ready  (eng_in_ready),
    .eng_in_data   (eng_in_data),
    .eng_out_valid (eng_out_valid),
    .eng_out_ready (eng_out_ready),
    .eng_out_data  (eng_out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_id        (out_id),
    .blk_cnt       (blk_cnt),
    .busy          (busy),
    .dbg_state     (dbg_state),
    .dbg_credit    (dbg_credit)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [BLK_W-1:0] blk(input int r);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int k = 0; k < 64; k++) begin
      b[k*32 +: 32] = (r == 1) ? 32'd100 : 32'(r * 1000 + k);
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int r);
    return blk_cnt[r*CNT_W +: CNT_W];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [BLK_W-1:0] obs,
                           input logic [BLK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed word0 %0h word63 %0h expected word0 %0h word63 %0h",
             tag, obs[31:0], obs[BLK_W-1 -: 32], exp[31:0], exp[BLK_W-1 -: 32]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for a downstream transfer, checks its tag and payload,
  // then returns 1 time unit after the transfer edge.
  task automatic wait_result(input string tag, input int exp_id);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(found), 64'd1);
    if (found) begin
      check({tag, "_id"}, 64'(out_id), 64'(exp_id));
      check_blk({tag, "_data"}, out_data, blk(exp_id));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- engine model ----------------
  initial begin
    logic             in_fire;
    logic             out_fire;
    logic [BLK_W-1:0] in_blk;
    logic [BLK_W-1:0] hold;
    logic             pend;
    int               timer;
    eng_out_valid = 1'b0;
    eng_out_data  = '0;
    pend  = 1'b0;
    timer = 0;
    hold  = '0;
    forever begin
      @(negedge clk);
      in_fire  = eng_in_valid && eng_in_ready;
      out_fire = eng_out_valid && eng_out_ready;
      in_blk   = eng_in_data;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        eng_out_valid = 1'b0;
        pend = 1'b0;
      end else begin
        if (out_fire) eng_out_valid = 1'b0;
        if (in_fire) begin
          pend  = 1'b1;
          timer = LAT;
          hold  = in_blk;
        end else if (pend) begin
          if (timer > 1) begin
            timer = timer - 1;
          end else begin
            eng_out_valid = 1'b1;
            eng_out_data  = hold;
            pend = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   pulses;
    logic found;
    logic hold_ok_v, hold_ok_d, hold_ok_er, hold_ok_rr, hold_ok_c;
    int   ue[8];
    ue = '{0, 0, 1, 2, 0, 0, 1, 2};

    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = {blk(2), blk(1), blk(0)};
    weight       = {4'd1, 4'd1, 4'd1};
    eng_in_ready = 1'b1;
    out_ready    = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_eng_in_valid", 64'(eng_in_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_eng_out_ready", 64'(eng_out_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_credit", 64'(dbg_credit), 64'd0);
    check_blk("rst_eng_in_data", eng_in_data, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester
    @(posedge clk);
    #1 req_valid = 3'b010;
    @(negedge clk);
    check("single_arb_in_valid", 64'(eng_in_valid), 64'd0);
    check("single_arb_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    check("single_issue_in_valid", 64'(eng_in_valid), 64'd1);
    check("single_issue_ready", 64'(req_ready), 64'b010);
    check_blk("single_issue_data", eng_in_data, blk(1));
    check("single_issue_busy", 64'(busy), 64'd1);
    pulses = 1;
    @(posedge clk);
    #1 req_valid = 3'b000;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready != '0) pulses++;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("single_out_seen", 64'(found), 64'd1);
    check("single_out_id", 64'(out_id), 64'd1);
    check_blk("single_out_data", out_data, blk(1));
    check("single_eng_out_ready", 64'(eng_out_ready), 64'd1);
    check("single_cnt_before", 64'(cnt_of(1)), 64'd0);
    check("single_ready_pulses", 64'(pulses), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_cnt_after", 64'(cnt_of(1)), 64'd1);
    check("single_busy_after", 64'(busy), 64'd0);
    check("single_out_valid_after", 64'(out_valid), 64'd0);

    // Equal weights
    do_reset();
    weight    = {4'd1, 4'd1, 4'd1};
    req_valid = 3'b111;
    for (int i = 0; i < 9; i++) begin
      wait_result($sformatf("eq_%0d", i), i % 3);
    end
    req_valid = 3'b000;
    @(negedge clk);
    check("eq_cnt0", 64'(cnt_of(0)), 64'd3);
    check("eq_cnt1", 64'(cnt_of(1)), 64'd3);
    check("eq_cnt2", 64'(cnt_of(2)), 64'd3);
    @(posedge clk);
    #1;

    // Unequal weights 2,1,0
    do_reset();
    weight    = {4'd0, 4'd1, 4'd2};
    req_valid = 3'b111;
    for (int i = 0; i < 8; i++) begin
      wait_result($sformatf("uneq_%0d", i), ue[i]);
    end
    req_valid = 3'b000;
    @(negedge clk);
    check("uneq_cnt0", 64'(cnt_of(0)), 64'd4);
    check("uneq_cnt1", 64'(cnt_of(1)), 64'd2);
    check("uneq_cnt2", 64'(cnt_of(2)), 64'd2);
    @(posedge clk);
    #1;

    // Output backpressure
    do_reset();
    weight    = {4'd1, 4'd1, 4'd1};
    req_valid = 3'b100;
    out_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_out_seen", 64'(found), 64'd1);
    hold_ok_v = 1'b1; hold_ok_d = 1'b1; hold_ok_er = 1'b1; hold_ok_rr = 1'b1; hold_ok_c = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c != 0) @(negedge clk);
      if (out_valid !== 1'b1) hold_ok_v = 1'b0;
      if (out_data !== blk(2)) hold_ok_d = 1'b0;
      if (eng_out_ready !== 1'b0) hold_ok_er = 1'b0;
      if (req_ready !== '0) hold_ok_rr = 1'b0;
      if (blk_cnt !== '0) hold_ok_c = 1'b0;
    end
    check("bp_out_valid_held", 64'(hold_ok_v), 64'd1);
    check("bp_out_data_stable", 64'(hold_ok_d), 64'd1);
    check("bp_eng_out_ready_low", 64'(hold_ok_er), 64'd1);
    check("bp_no_req_ready", 64'(hold_ok_rr), 64'd1);
    check("bp_cnt_unchanged", 64'(hold_ok_c), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    req_valid = 3'b000;
    @(negedge clk);
    check("bp_release_out_valid", 64'(out_valid), 64'd1);
    check("bp_release_eng_out_ready", 64'(eng_out_ready), 64'd1);
    check("bp_release_cnt_before", 64'(cnt_of(2)), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_cnt_after", 64'(cnt_of(2)), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);

    // Reset mid-operation
    @(posedge clk);
    #1;
    do_reset();
    weight    = {4'd1, 4'd1, 4'd1};
    req_valid = 3'b110;
    wait_result("mid_first", 1);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reach_wait", 64'(found), 64'd1);
    check("mid_cnt1_before", 64'(cnt_of(1)), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_eng_in_valid", 64'(eng_in_valid), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_eng_out_ready", 64'(eng_out_ready), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_blk_cnt", 64'(blk_cnt), 64'd0);
    req_valid = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_result("mid_after", 0);
    req_valid = 3'b000;

    // Forfeit: requester 0 weight 3 stops after one block
    do_reset();
    weight    = {4'd5, 4'd1, 4'd3};
    req_valid = 3'b001;
    wait_result("ff_first", 0);
    req_valid = 3'b100;
    @(negedge clk);
    check("ff_arb_state", 64'(dbg_state), 64'd0);
    check("ff_arb_credit", 64'(dbg_credit), 64'd2);
    @(negedge clk);
    check("ff_issue_state", 64'(dbg_state), 64'd1);
    check("ff_issue_grant", 64'(out_id), 64'd2);
    check("ff_issue_credit", 64'(dbg_credit), 64'd5);
    check("ff_issue_ready", 64'(req_ready), 64'b100);
    wait_result("ff_second", 2);
    req_valid = 3'b000;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_block_arbiter.md
# dct_block_arbiter

Weighted round-robin scheduler that shares one 8×8 2-D DCT engine between up to NREQ block producers, e.g. Y, Cb and Cr tile streams. It sits between the producers and the single-instance `dct8x8_chen_2d` engine. It passes one 64-point block at a time to the engine, holds ownership until that block's result has been returned downstream, and tags the result with the producer index. Block payloads are muxed combinationally, so the block stores no 64-point data.

## Interface
- `IN_W`, 32, coefficient width; must match the engine.
- `NREQ`, 3, number of requesters (2..8).
- `CNT_W`, 16, width of each per-requester block counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester block valid.
- `req_ready`  out  NREQ  per-requester block accepted.
- `req_data`  in  NREQ·64·IN_W  requester r occupies slice `[r*64*IN_W +: 64*IN_W]`.
- `weight`  in  NREQ·4  consecutive-grant budget per requester; 0 is treated as 1.
- `eng_in_valid`  out  1  block valid to the engine.
- `eng_in_ready`  in  1  engine ready for a block.
- `eng_in_data`  out  64·IN_W  block to the engine.
- `eng_out_valid`  in  1  engine result valid.
- `eng_out_ready`  out  1  result accepted from the engine.
- `eng_out_data`  in  64·IN_W  engine result.
- `out_valid`  out  1  tagged result valid.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  64·IN_W  result data; equals `eng_out_data`.
- `out_id`  out  3  index of the owning requester.
- `blk_cnt`  out  NREQ·CNT_W  completed blocks per requester; wraps modulo 2^CNT_W.
- `busy`  out  1  high in any state other than S_ARB.

## Operation
- **Registered state:** `state`, `grant` (3 bits), `last` (3 bits), `credit` (4 bits), `blk_cnt`.
- **S_ARB:**
  - If `credit>0` and `req_valid[grant]`: keep `grant`.
  - Otherwise, if any `req_valid` is set: set `grant` to the first valid index searching `last+1, last+2, …` modulo NREQ. Set `last<=grant` and `credit<=max(weight[grant],1)`.
  - Then go to S_ISSUE. If no request is valid, stay in S_ARB and set `credit<=0`.
- **S_ISSUE:**
  - `eng_in_valid = req_valid[grant]`.
  - `eng_in_data = req_data` slice of `grant`.
  - `req_ready[grant] = eng_in_ready`; all other `req_ready` bits are 0.
  - When `req_valid[grant] && eng_in_ready`, go to S_WAIT.
  - If the owner drops valid (protocol violation), stay in S_ISSUE.
- **S_WAIT:**
  - `out_valid = eng_out_valid`, `eng_out_ready = out_ready`, `out_id = grant`.
  - On `eng_out_valid && out_ready`:
    - `blk_cnt[grant]++` (wraps).
    - `credit <= credit-1`.
    - Go to S_ARB.
- **Outside their states:** `eng_in_valid`, `req_ready`, `out_valid` and `eng_out_ready` are 0. `out_id` holds `grant`.
- **Fairness:** a requester keeps at most `weight` consecutive grants, then the pointer moves on. If a requester has no valid block when its turn comes, it forfeits the rest of its credit.
- **Weight sampling:** `weight` is sampled only when a new grant is made. Changing it mid-burst has no effect until the next grant.
- **Engine results:** any result arriving outside S_WAIT is held off with `eng_out_ready=0`. It cannot occur with a conforming engine.

## Timing
- **Reset values:**
  - `state=S_ARB`, `grant=0`, `last=NREQ-1` (requester 0 wins first), `credit=0`, `blk_cnt=0`.
  - All outputs 0 except `out_data`, which follows `eng_out_data`.
- **Arbitration:** takes exactly 1 cycle (S_ARB). The earliest `eng_in_valid` is the cycle after the first `req_valid` is seen.
- **Round-trip overhead:** one S_ARB cycle per block on top of engine latency. Blocks are strictly serialised; at most one is outstanding.
- **Pass-through handshakes:** the `req` to `eng_in` and `eng_out` to `out` handshakes are combinational, with no added latency. `eng_in_valid` must never depend on `eng_in_ready`.
- **Simultaneous events:**
  - A result transfer and a new request arriving in the same cycle: the request is arbitrated in the next cycle, in S_ARB.
  - Several requesters valid at once: the first in round-robin order wins.
- **Reset mid-operation:**
  - Any in-flight block is abandoned and `blk_cnt` clears.
  - The engine shares `rst_n`, so its pipeline clears too.
  - The producer must re-present the block.

## Test plan
- **Single requester:** reset, then `req_valid[1]=1` with a constant-100 block; engine model has 20-cycle latency; `out_ready=1`. Required: `req_ready[1]` pulses once, `out_valid` comes with `out_id=1`, `blk_cnt[1]=1`, `busy` is back to 0 after the transfer.
- **Equal weights:** all three requesters continuously valid, `weight=1,1,1`, 9 blocks. Required: `out_id` sequence is 0,1,2,0,1,2,0,1,2 and every `blk_cnt` equals 3.
- **Unequal weights:** `weight=2,1,0`, all three valid, 8 blocks. Required: `out_id` sequence is 0,0,1,2,0,0,1,2 (weight 0 acts as 1).
- **Output backpressure:** `out_ready` held low for 50 cycles after the engine result. Required: `out_valid` held, `out_data` stable, `eng_out_ready=0`, no new `req_ready`, `blk_cnt` unchanged until release.
- **Reset mid-operation:** assert `rst_n` low while in S_WAIT. Required: within the same cycle all handshake outputs are 0 and `blk_cnt` is 0. After release, requester 0 is granted first.
- **Forfeit:** requester 0 has weight 3 but drops valid after 1 block; requester 2 is valid. Required: the next grant goes to requester 2 and `credit` is reloaded to `weight[2]`.
